// File: rtl/clock_pkg.sv
// clock_pkg: mode and button encodings shared by the button front end and clock_top
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_SET_DATE  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_REPEAT
    } rep_state_t;

    localparam int BTN_UNITS = 0;
    localparam int BTN_TENS  = 1;
    localparam int BTN_3     = 2;
    localparam int BTN_AMPM  = 3;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: 2-flop synchronizer, stability counter and rising-edge detect for one button
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 32
) (
    input  logic mclk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             s;

    assign s     = sync[1];
    assign press = s && !stable && cnt == LAST;

    // Accept a new level only after it has been seen unchanged for DEBOUNCE_CYCLES samples
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (s == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= s;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: raw buttons to debounced, auto-repeating one-cycle pulses plus the mode FSM
module button_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8,
    parameter int IDLE_TIMEOUT    = 100,
    parameter int CNT_W           = 32
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [3:0] pButton,
    input  logic       pMode,
    output logic [3:0] vButton,
    output logic [1:0] clk_mode
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_TIMEOUT - 1);

    logic [4:0]       raw;
    logic [4:0]       stable;
    logic [4:0]       press;
    mode_t            mode;
    rep_state_t       rep_state [3];
    logic [CNT_W-1:0] rep_cnt [3];
    logic [CNT_W-1:0] idle_cnt;
    logic [2:0]       rep_pulse;
    logic [3:0]       pulse_next;
    logic             mode_press;
    logic             timeout;
    logic             mode_change;
    logic             unused_stable;

    assign raw           = {pMode, pButton};
    assign clk_mode      = mode;
    assign mode_press    = press[4];
    assign unused_stable = &{1'b0, stable[4:3]};

    genvar i;
    for (i = 0; i < 5; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .mclk  (mclk),
            .rst   (rst),
            .raw   (raw[i]),
            .stable(stable[i]),
            .press (press[i])
        );
    end

    // Terminal count of each repeat channel; a released button never fires
    always_comb begin
        rep_pulse = '0;
        for (int k = 0; k <= BTN_3; k++)
            rep_pulse[k] = stable[k] && ((rep_state[k] == REP_DELAY && rep_cnt[k] == DELAY_LAST) ||
                                         (rep_state[k] == REP_REPEAT && rep_cnt[k] == PERIOD_LAST));
    end

    // A pMode press owns the cycle and swallows any coincident button pulse; it also beats a timeout
    always_comb begin
        pulse_next  = mode_press ? 4'b0 : press[BTN_AMPM:0] | {1'b0, rep_pulse};
        timeout     = mode != MODE_RUN && idle_cnt == IDLE_LAST && pulse_next == 4'b0;
        mode_change = mode_press || timeout;
    end

    // Per-channel auto-repeat; any mode change drops every channel to idle until it is re-pressed
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= BTN_3; k++) begin
                rep_state[k] <= REP_IDLE;
                rep_cnt[k]   <= '0;
            end
        end else begin
            for (int k = 0; k <= BTN_3; k++) begin
                if (mode_change || (rep_state[k] != REP_IDLE && !stable[k])) begin
                    rep_state[k] <= REP_IDLE;
                    rep_cnt[k]   <= '0;
                end else if (rep_state[k] == REP_IDLE) begin
                    if (press[k] && mode != MODE_RUN) begin
                        rep_state[k] <= REP_DELAY;
                        rep_cnt[k]   <= '0;
                    end
                end else if (rep_pulse[k]) begin
                    rep_state[k] <= REP_REPEAT;
                    rep_cnt[k]   <= '0;
                end else begin
                    rep_cnt[k] <= rep_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Mode FSM, registered pulse output and the idle counter that forces a return to run mode
    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            mode     <= MODE_RUN;
            vButton  <= '0;
            idle_cnt <= '0;
        end else begin
            vButton  <= pulse_next;
            mode     <= mode_press ? mode_t'(mode + 2'd1) : (timeout ? MODE_RUN : mode);
            idle_cnt <= (mode == MODE_RUN || mode_change || pulse_next != 4'b0) ? '0 : idle_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, repeat timing, mode FSM, timeout and reset
module tb_button_conditioner;
    import clock_pkg::*;

    logic       mclk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pButton = 4'b0;
    logic       pMode = 1'b0;
    logic [3:0] vButton;
    logic [1:0] clk_mode;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wch = 0;
    int d, q, r, m;
    int n_p [4];
    int pt [$];
    int rep_exp [6] = '{0, 20, 28, 36, 44, 52};

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8),
        .IDLE_TIMEOUT   (100),
        .CNT_W          (32)
    ) dut (
        .mclk    (mclk),
        .rst     (rst),
        .pButton (pButton),
        .pMode   (pMode),
        .vButton (vButton),
        .clk_mode(clk_mode)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge mclk);
        cyc++;
        for (int c = 0; c < 4; c++)
            if (vButton[c] === 1'b1) begin
                n_p[c]++;
                if (c == wch) pt.push_back(cyc);
            end
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic clear_log(input int ch);
        wch = ch;
        pt.delete();
        for (int c = 0; c < 4; c++) n_p[c] = 0;
    endtask

    function automatic int ptd(input int k);
        return (pt.size() > k) ? pt[k] - pt[0] : -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("reset_vbutton", vButton, 4'b0);
        check("reset_mode", clk_mode, MODE_RUN);
        tick();
        tick();
        rst = 1'b1;
        cyc = 0;
        // single press in run mode: sampled at edge 10, pulse after edge 15, no repeat
        clear_log(BTN_UNITS);
        run_to(9);
        pButton[0] = 1'b1;
        run_to(14);
        check("t1_before", vButton, 4'b0);
        tick();
        check("t1_pulse", vButton, 4'b0001);
        tick();
        check("t1_width", vButton, 4'b0);
        run_to(200);
        check("t1_count", n_p[0], 1);
        pButton[0] = 1'b0;
        run_to(215);
        check("t1_release", n_p[0], 1);
        check("t1_mode", clk_mode, MODE_RUN);
        // bounce on tens never reaches the debounce count
        clear_log(BTN_TENS);
        pButton[1] = 1'b1; tick();
        pButton[1] = 1'b0; tick();
        pButton[1] = 1'b1; tick();
        tick();
        pButton[1] = 1'b0;
        run_to(cyc + 20);
        check("t2_bounce", n_p[1], 0);
        // four mode presses walk 0->1->2->3->0
        for (int j = 0; j < 4; j++) begin
            d = cyc;
            pMode = 1'b1;
            run_to(d + 5);
            check("t3_before", clk_mode, j);
            run_to(d + 6);
            check("t3_after", clk_mode, (j + 1) % 4);
            run_to(d + 10);
            pMode = 1'b0;
            run_to(d + 20);
        end
        // enter set time, hold units 56 cycles: first pulse then repeat train
        d = cyc;
        pMode = 1'b1;
        run_to(d + 10);
        pMode = 1'b0;
        run_to(d + 20);
        check("t4_mode", clk_mode, MODE_SET_TIME);
        clear_log(BTN_UNITS);
        d = cyc;
        pButton[0] = 1'b1;
        run_to(d + 56);
        pButton[0] = 1'b0;
        run_to(d + 80);
        check("t4_first", (pt.size() > 0) ? pt[0] - d : -1, 6);
        check("t4_count", pt.size(), 6);
        for (int k = 1; k < 6; k++) check("t4_gap", ptd(k), rep_exp[k]);
        check("t4_mode_kept", clk_mode, MODE_SET_TIME);
        // setampm never repeats
        clear_log(BTN_AMPM);
        d = cyc;
        pButton[3] = 1'b1;
        run_to(d + 56);
        pButton[3] = 1'b0;
        run_to(d + 70);
        check("t4_ampm_count", n_p[3], 1);
        check("t4_ampm_first", (pt.size() > 0) ? pt[0] - d : -1, 6);
        // set alarm with no presses times out exactly 100 cycles after entry
        d = cyc;
        pMode = 1'b1;
        run_to(d + 6);
        check("t5_entry", clk_mode, MODE_SET_ALARM);
        run_to(d + 10);
        pMode = 1'b0;
        run_to(d + 105);
        check("t5_hold", clk_mode, MODE_SET_ALARM);
        run_to(d + 106);
        check("t5_timeout", clk_mode, MODE_RUN);
        // a press 90 cycles into set alarm restarts the idle count
        d = cyc;
        pMode = 1'b1;
        run_to(d + 10);
        pMode = 1'b0;
        run_to(d + 20);
        pMode = 1'b1;
        run_to(d + 26);
        check("t5_reentry", clk_mode, MODE_SET_ALARM);
        m = d + 26;
        run_to(d + 30);
        pMode = 1'b0;
        run_to(m + 84);
        pButton[0] = 1'b1;
        run_to(m + 90);
        check("t5_press", vButton, 4'b0001);
        run_to(m + 92);
        pButton[0] = 1'b0;
        run_to(m + 100);
        check("t5_restart", clk_mode, MODE_SET_ALARM);
        run_to(m + 189);
        check("t5_late_hold", clk_mode, MODE_SET_ALARM);
        run_to(m + 190);
        check("t5_late_timeout", clk_mode, MODE_RUN);
        // button3 held in repeat, mode advance locks it out until release
        d = cyc;
        pMode = 1'b1;
        run_to(d + 10);
        pMode = 1'b0;
        run_to(d + 20);
        check("t6_mode1", clk_mode, MODE_SET_TIME);
        clear_log(BTN_3);
        q = cyc;
        pButton[2] = 1'b1;
        run_to(q + 30);
        pMode = 1'b1;
        run_to(q + 36);
        check("t6_adv", clk_mode, MODE_SET_ALARM);
        run_to(q + 40);
        pMode = 1'b0;
        run_to(q + 80);
        check("t6_locked", n_p[2], 3);
        check("t6_last", (pt.size() > 2) ? pt[2] - q : -1, 34);
        pButton[2] = 1'b0;
        run_to(q + 90);
        pButton[2] = 1'b1;
        run_to(q + 95);
        check("t6_repress_before", vButton, 4'b0);
        run_to(q + 96);
        check("t6_repress", vButton, 4'b0100);
        run_to(q + 116);
        check("t6_delay_pulse", vButton, 4'b0100);
        check("t6_mode_before_rst", clk_mode, MODE_SET_ALARM);
        rst = 1'b0;
        #1;
        check("t6_rst_vbutton", vButton, 4'b0);
        check("t6_rst_mode", clk_mode, MODE_RUN);
        tick();
        rst = 1'b1;
        r = cyc;
        clear_log(BTN_3);
        run_to(r + 5);
        check("t6_redebounce_before", vButton, 4'b0);
        run_to(r + 6);
        check("t6_redebounce", vButton, 4'b0100);
        run_to(r + 40);
        check("t6_single", n_p[2], 1);
        check("t6_end_mode", clk_mode, MODE_RUN);
        pButton[2] = 1'b0;
        run_to(r + 50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
